sccb_init_sequencer: RTL
========================

# sccb_init_sequencer

Register-initialisation sequencer sitting directly upstream of the SCCB transceiver core. After power-up, or on request, it walks a table of (sub-address, data) pairs for the OV7670 and issues one 3-phase write per entry. It drives the core's address, data and phase inputs, waits for the matching phase-done pulse, and inserts the settle delays the camera requires. It reports busy, done and timeout status to the top level.

## Interface
- `SYS_CLK_FREQ`, 100_000_000, system clock frequency in Hz.
- `MAIN_ADDR`, 8'h42, SCCB write ID of the camera.
- `STARTUP_DELAY_MS`, 10, wait after reset before the first write.
- `SWRESET_DELAY_MS`, 1, extra wait after any write of 8'h80 to sub-address 8'h12 (COM7 soft reset).
- `GAP_CYCLES`, 1000, idle cycles between consecutive writes.
- `TIMEOUT_CYCLES`, 2_000_000, maximum wait for phase-done per write.
- `i_clk  in  1`  system clock; all logic is posedge.
- `i_reset_p  in  1`  asynchronous, active-high reset.
- `i_start  in  1`  one-cycle pulse that restarts the sequence from entry 0; ignored while busy.
- `i_phase_done  in  3`  phase-done pulses from the transceiver; only bit 0 is used.
- `o_main_addr  out  8`  constant `MAIN_ADDR`.
- `o_sub_addr  out  8`  sub-address of the current entry.
- `o_data  out  8`  data byte of the current entry.
- `o_phase  out  3`  phase request to the transceiver; only bit 0 is ever driven high.
- `o_busy  out  1`  high from sequence start until DONE or ERROR.
- `o_done  out  1`  level; high after the end marker is reached, cleared on restart.
- `o_error  out  1`  level; high after a timeout, cleared on restart.
- `o_index  out  8`  index of the current or last table entry.

## Operation
- Reset values: `o_sub_addr`=0, `o_data`=0, `o_phase`=3'b000, `o_busy`=1, `o_done`=0, `o_error`=0, `o_index`=0. State is STARTUP_WAIT with the counter at 0, so a sequence runs automatically after reset.
- State machine:
  - **STARTUP_WAIT:** count `STARTUP_DELAY_MS*SYS_CLK_FREQ/1000` cycles, then go to FETCH.
  - **FETCH:** latch the ROM entry at `o_index` into `o_sub_addr`/`o_data`. Entry 16'hFFFF is the end marker and goes to DONE. Any other entry goes to ISSUE.
  - **ISSUE:** assert `o_phase[0]` and go to WAIT_DONE.
  - **WAIT_DONE:** hold `o_phase[0]`=1, with address and data stable, until `i_phase_done[0]`.
    - On done: drop `o_phase[0]` in the same clock and go to GAP. If the entry was {8'h12, 8'h80}, preload GAP with `SWRESET_DELAY_MS*SYS_CLK_FREQ/1000` cycles instead of `GAP_CYCLES`.
    - If the watchdog reaches `TIMEOUT_CYCLES` first: drop `o_phase`, set `o_error`, go to ERROR.
  - **GAP:** count the preloaded value, increment `o_index`, go to FETCH.
  - **DONE / ERROR:** idle with `o_busy`=0. `i_start` clears `o_done`/`o_error`, sets `o_index`=0, sets `o_busy`=1, and goes to FETCH (no startup wait).
- Handshake rules:
  - The transceiver is edge-triggered on `o_phase[0]`, so `o_phase[0]` is always low for at least `GAP_CYCLES` (≥1) between requests.
  - `o_sub_addr`/`o_data` are unchanged from ISSUE until done.
- `i_phase_done[0]` outside WAIT_DONE is ignored. `i_phase_done[2:1]` are always ignored.
- The index is 8 bits wide. Reaching 255 without an end marker forces DONE after entry 255.
- Reset mid-write: `o_phase` goes to 0 immediately and the sequence restarts from STARTUP_WAIT.

## Timing
- Reset release to first `o_phase[0]` rise: startup count plus 2 cycles (FETCH, ISSUE).
- `i_phase_done[0]` at cycle n gives `o_phase[0]`=0 at n+1.
- Next rise of `o_phase[0]` is at n+1+gap+2.
- The ROM is combinational. The FETCH latch makes address and data valid one cycle before the `o_phase` rise.
- The watchdog counter clears on entry to WAIT_DONE. A timeout fires on the cycle the counter equals `TIMEOUT_CYCLES-1`.
- Delay counters are 32-bit. Counts are computed from the parameters at elaboration; a zero count lasts 1 cycle.

## Structure
- A shared package `ov7670_pkg` holds:
  - the state encoding;
  - `OV7670_WRITE_ID` (8'h42);
  - `REG_COM7` (8'h12) and `COM7_SWRESET` (8'h80);
  - `ROM_END` (16'hFFFF).
- Sub-module `ov7670_reg_rom`: 8-bit index in, 16-bit {sub_addr, data} out, combinational case statement, with `ROM_END` as the default.

## Test plan
- Use simulation parameters `SYS_CLK_FREQ`=1_000_000, `STARTUP_DELAY_MS`=1, `GAP_CYCLES`=4, `TIMEOUT_CYCLES`=50, together with a behavioural transceiver model that pulses done 20 cycles after `o_phase[0]` rises.
- Release reset → first `o_phase[0]` rise at cycle 1002; `o_sub_addr`/`o_data` equal ROM entry 0.
- Entry {8'h12, 8'h80} → next `o_phase[0]` rise 1000+3 cycles after its done pulse, not 4+3.
- Run the full table with a 3-entry ROM plus end marker → exactly 3 writes; `o_done`=1, `o_busy`=0, `o_index`=3.
- Model never returns done → `o_phase[0]` falls and `o_error`=1 exactly 50 cycles after the rise; a later `i_start` clears the error and rewrites entry 0.
- Assert reset during WAIT_DONE → `o_phase`=0 in the same cycle; the sequence restarts with the startup wait.
- Spurious `i_phase_done[0]` in GAP and `i_start` while busy → no change to index or state.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 register-initialisation sequencer.
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_STARTUP_WAIT = 3'd0,
    ST_FETCH        = 3'd1,
    ST_ISSUE        = 3'd2,
    ST_WAIT_DONE    = 3'd3,
    ST_GAP          = 3'd4,
    ST_DONE         = 3'd5,
    ST_ERROR        = 3'd6
  } seq_state_e;

  localparam logic [7:0]  OV7670_WRITE_ID = 8'h42;
  localparam logic [7:0]  REG_COM7        = 8'h12;
  localparam logic [7:0]  COM7_SWRESET    = 8'h80;
  localparam logic [15:0] ROM_END         = 16'hFFFF;

  function automatic logic [31:0] ms_to_cycles(input longint ms, input longint clk_hz);
    return 32'((ms * clk_hz) / 64'sd1000);
  endfunction

  // Delay counters run up from 0 and stop on this value; a zero delay still takes one cycle.
  function automatic logic [31:0] terminal_count(input logic [31:0] cycles);
    return (cycles == 32'd0) ? 32'd0 : cycles - 32'd1;
  endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// Combinational table of {sub_addr, data} pairs written to the OV7670 at init.
module ov7670_reg_rom
  import ov7670_pkg::*;
(
  input  logic [7:0]  index,
  output logic [15:0] entry
);

  always_comb begin
    case (index)
      8'd0:    entry = {REG_COM7, COM7_SWRESET};
      8'd1:    entry = 16'h1204;
      8'd2:    entry = 16'h40D0;
      default: entry = ROM_END;
    endcase
  end

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks the OV7670 register ROM and issues one SCCB 3-phase write per entry,
// with startup, soft-reset settle and inter-write gaps plus a per-write watchdog.
//
// state        | meaning
// STARTUP_WAIT | power-up settle before the first write
// FETCH        | latch ROM entry at o_index; end marker finishes
// ISSUE        | raise o_phase[0]
// WAIT_DONE    | hold request until phase-done or watchdog expiry
// GAP          | phase low for the preloaded delay, then next entry
// DONE         | table finished, idle until i_start
// ERROR        | watchdog expired, idle until i_start
module sccb_init_sequencer
  import ov7670_pkg::*;
#(
  parameter int         SYS_CLK_FREQ     = 100_000_000,
  parameter logic [7:0] MAIN_ADDR        = OV7670_WRITE_ID,
  parameter int         STARTUP_DELAY_MS = 10,
  parameter int         SWRESET_DELAY_MS = 1,
  parameter int         GAP_CYCLES       = 1000,
  parameter int         TIMEOUT_CYCLES   = 2_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset_p,
  input  logic       i_start,
  input  logic [2:0] i_phase_done,
  output logic [7:0] o_main_addr,
  output logic [7:0] o_sub_addr,
  output logic [7:0] o_data,
  output logic [2:0] o_phase,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  output logic [7:0] o_index
);

  localparam logic [31:0] STARTUP_LAST =
    terminal_count(ms_to_cycles(longint'(STARTUP_DELAY_MS), longint'(SYS_CLK_FREQ)));
  localparam logic [31:0] SWRESET_LAST =
    terminal_count(ms_to_cycles(longint'(SWRESET_DELAY_MS), longint'(SYS_CLK_FREQ)));
  localparam logic [31:0] GAP_LAST = terminal_count(32'(GAP_CYCLES));
  localparam logic [31:0] WD_LAST  = terminal_count(32'(TIMEOUT_CYCLES));

  seq_state_e  state_q, state_d;
  logic [7:0]  index_q, index_d;
  logic [7:0]  sub_q, sub_d;
  logic [7:0]  data_q, data_d;
  logic        phase_q, phase_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [31:0] dly_cnt_q, dly_cnt_d;
  logic [31:0] dly_last_q, dly_last_d;
  logic [31:0] wd_cnt_q, wd_cnt_d;

  logic [15:0] rom_entry;
  logic        rom_is_end;
  logic        dly_hit;
  logic        wd_hit;
  logic        phase_ack;
  logic        swreset_entry;
  logic        unused_phase_done;

  ov7670_reg_rom u_rom (
    .index (index_q),
    .entry (rom_entry)
  );

  assign rom_is_end        = (rom_entry == ROM_END);
  assign dly_hit           = (dly_cnt_q == dly_last_q);
  assign wd_hit            = (wd_cnt_q == WD_LAST);
  assign phase_ack         = i_phase_done[0];
  assign swreset_entry     = (sub_q == REG_COM7) && (data_q == COM7_SWRESET);
  assign unused_phase_done = ^i_phase_done[2:1];

  always_ff @(posedge i_clk or posedge i_reset_p) begin
    if (i_reset_p) begin
      state_q    <= ST_STARTUP_WAIT;
      index_q    <= 8'd0;
      sub_q      <= 8'd0;
      data_q     <= 8'd0;
      phase_q    <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      dly_cnt_q  <= 32'd0;
      dly_last_q <= STARTUP_LAST;
      wd_cnt_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      sub_q      <= sub_d;
      data_q     <= data_d;
      phase_q    <= phase_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      dly_cnt_q  <= dly_cnt_d;
      dly_last_q <= dly_last_d;
      wd_cnt_q   <= wd_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STARTUP_WAIT: if (dly_hit) state_d = ST_FETCH;
      ST_FETCH:        state_d = rom_is_end ? ST_DONE : ST_ISSUE;
      ST_ISSUE:        state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (phase_ack)   state_d = ST_GAP;
        else if (wd_hit) state_d = ST_ERROR;
      end
      ST_GAP: begin
        if (dly_hit) state_d = (index_q == 8'hFF) ? ST_DONE : ST_FETCH;
      end
      ST_DONE, ST_ERROR: if (i_start) state_d = ST_FETCH;
      default:           state_d = ST_STARTUP_WAIT;
    endcase
  end

  always_comb begin
    index_d    = index_q;
    sub_d      = sub_q;
    data_d     = data_q;
    phase_d    = phase_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    dly_cnt_d  = dly_cnt_q;
    dly_last_d = dly_last_q;
    wd_cnt_d   = wd_cnt_q;
    case (state_q)
      ST_STARTUP_WAIT: dly_cnt_d = dly_cnt_q + 32'd1;
      ST_FETCH: begin
        sub_d  = rom_entry[15:8];
        data_d = rom_entry[7:0];
        if (rom_is_end) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        phase_d  = 1'b1;
        wd_cnt_d = 32'd0;
      end
      ST_WAIT_DONE: begin
        wd_cnt_d = wd_cnt_q + 32'd1;
        if (phase_ack) begin
          phase_d    = 1'b0;
          dly_cnt_d  = 32'd0;
          // COM7 soft reset needs the sensor to settle before it accepts more writes
          dly_last_d = swreset_entry ? SWRESET_LAST : GAP_LAST;
        end else if (wd_hit) begin
          phase_d = 1'b0;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_GAP: begin
        dly_cnt_d = dly_cnt_q + 32'd1;
        if (dly_hit) begin
          if (index_q == 8'hFF) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            index_d = index_q + 8'd1;
          end
        end
      end
      ST_DONE, ST_ERROR: begin
        if (i_start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          index_d = 8'd0;
          busy_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_main_addr = MAIN_ADDR;
  assign o_sub_addr  = sub_q;
  assign o_data      = data_q;
  assign o_phase     = {2'b00, phase_q};
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_error     = error_q;
  assign o_index     = index_q;

endmodule
